lod_round_pipe: RTL

LOD_ROUND_PIPE -- requirements
Module: lod_round_pipe

---
 rtl/lod_round_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/lod_round_pipe.sv
// Two-stage leading-one detector that feeds a power-of-two rounding mux: S1 captures the
// operand and its leading-one index, and S2 registers the mux data (pow2) and select bit.
module lod_round_pipe #(
    parameter int WIDTH      = 16,
    parameter int LOG2_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    pow2,
    output logic                  decision_bit,
    output logic [LOG2_WIDTH-1:0] lod_index,
    output logic                  is_zero,
    output logic [15:0]           round_up_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready is true. A valid
    // producer holds its data until that transfer, and ready may depend on the valid of
    // the stage downstream of it.

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_operand;
    logic [LOG2_WIDTH-1:0] s1_k;
    logic                  s1_zero;

    logic                  s2_valid;

    logic [LOG2_WIDTH-1:0] lead_k;
    logic                  lead_zero;
    logic                  out_xfer;
    logic                  s2_load;
    logic [2*WIDTH-1:0]    next_pow2;
    logic                  next_decision;

    // Priority encoder: the scan runs upward, so the highest set bit is assigned last and wins.
    always_comb begin
        lead_k    = '0;
        lead_zero = (operand == '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (operand[i]) begin
                lead_k = LOG2_WIDTH'(i);
            end
        end
    end

    assign out_xfer  = s2_valid && out_ready;
    assign s2_load   = !s2_valid || out_xfer;
    assign in_ready  = rst_n && (!s1_valid || s2_load);
    assign out_valid = s2_valid;

    // k=0 has no bit below it, so the select is 0. A zero operand also gives k=0.
    always_comb begin
        next_pow2     = '0;
        next_decision = 1'b0;
        if (!s1_zero) begin
            next_pow2 = (2*WIDTH)'(1) << s1_k;
        end
        if (s1_k != '0) begin
            next_decision = s1_operand[s1_k - 1'b1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_k       <= '0;
            s1_zero    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_operand <= operand;
                s1_k       <= lead_k;
                s1_zero    <= lead_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            pow2         <= '0;
            decision_bit <= 1'b0;
            lod_index    <= '0;
            is_zero      <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                pow2         <= next_pow2;
                decision_bit <= next_decision;
                lod_index    <= s1_k;
                is_zero      <= s1_zero;
            end
        end
    end

    // Counts only delivered round-ups. The count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_up_cnt <= '0;
        end else if (out_xfer && decision_bit && (round_up_cnt != 16'hFFFF)) begin
            round_up_cnt <= round_up_cnt + 16'd1;
        end
    end

endmodule
